// File: rtl/sc_level_sequencer.sv
// sc_level_sequencer
//   Game-flow controller for Frogger. It drives the external progress counter
//   (clear / run enable / active-low count strobe), watches the counter value
//   against the crossing goal, and keeps track of the level number and the
//   remaining lives. WIN and GAME OVER are flagged for the display logic.
//
// Ports
//   SC_LEVELSEQUENCER_CLOCK_50      system clock
//   SC_LEVELSEQUENCER_RESET_InHigh  synchronous reset, active high
//   start_in        start button pulse
//   step_in         frog advanced one row (pulse)
//   collision_in    frog hit / drowned (pulse)
//   tick_in         frame tick (pulse), paces the banner pause
//   progress_in     current progress counter value
//   cnt_count_n_out counter count strobe, active low
//   cnt_clear_out   counter synchronous clear
//   cnt_enable_out  counter run enable
//   level_out       current level, 0-based
//   lives_out       remaining lives
//   state_out       FSM state code for the display mux
//   win_out         high while in WIN
//   gameover_out    high while in GAMEOVER
//
// Every output comes straight from a flop, so a decision taken in one cycle
// shows up on the outputs in the next.

module sc_level_sequencer #(
  parameter int PROGRESS_WIDTH = 5,
  parameter int PROGRESS_GOAL  = 12,
  parameter int LEVEL_WIDTH    = 3,
  parameter int MAX_LEVEL      = 4,
  parameter int LIVES_INIT     = 3,
  parameter int BANNER_TICKS   = 8
) (
  input  logic                      SC_LEVELSEQUENCER_CLOCK_50,
  input  logic                      SC_LEVELSEQUENCER_RESET_InHigh,
  input  logic                      start_in,
  input  logic                      step_in,
  input  logic                      collision_in,
  input  logic                      tick_in,
  input  logic [PROGRESS_WIDTH-1:0] progress_in,
  output logic                      cnt_count_n_out,
  output logic                      cnt_clear_out,
  output logic                      cnt_enable_out,
  output logic [LEVEL_WIDTH-1:0]    level_out,
  output logic [1:0]                lives_out,
  output logic [2:0]                state_out,
  output logic                      win_out,
  output logic                      gameover_out
);

  localparam int BANNER_WIDTH = $clog2(BANNER_TICKS + 1);

  localparam logic [PROGRESS_WIDTH-1:0] GOAL       = PROGRESS_WIDTH'(PROGRESS_GOAL);
  localparam logic [LEVEL_WIDTH-1:0]    LAST_LEVEL = LEVEL_WIDTH'(MAX_LEVEL - 1);
  localparam logic [1:0]                LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [BANNER_WIDTH-1:0]   LAST_TICK  = BANNER_WIDTH'(BANNER_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    PLAY     = 3'd2,
    HIT      = 3'd3,
    BANNER   = 3'd4,
    LEVELUP  = 3'd5,
    WIN      = 3'd6,
    GAMEOVER = 3'd7
  } seqState_t;

  seqState_t                state_q, state_d;
  logic [LEVEL_WIDTH-1:0]   level_q, level_d;
  logic [1:0]               lives_q, lives_d;
  logic [BANNER_WIDTH-1:0]  bannerCnt_q, bannerCnt_d;
  logic                     countN_q, countN_d;
  logic                     clear_q, clear_d;
  logic                     enable_q, enable_d;
  logic                     win_q, win_d;
  logic                     gameover_q, gameover_d;

  // Next-state logic for the game flow, plus the level / lives / banner
  // bookkeeping that rides along with each transition. Level and lives are
  // loaded on the way into LOAD so the fresh values are already on display
  // during LOAD. In PLAY a collision beats a reached goal, and a reached goal
  // beats a step, so the strobe is never raised on the cycle that ends play.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    bannerCnt_d = bannerCnt_q;
    countN_d    = 1'b1;

    case (state_q)
      IDLE, WIN, GAMEOVER: begin
        if (start_in) begin
          state_d = LOAD;
          level_d = '0;
          lives_d = LIVES_LOAD;
        end
      end

      LOAD: begin
        state_d = PLAY;
      end

      PLAY: begin
        if (collision_in) begin
          state_d = HIT;
        end else if (progress_in >= GOAL) begin
          state_d = LEVELUP;
        end else if (step_in) begin
          countN_d = 1'b0;
        end
      end

      HIT: begin
        if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = GAMEOVER;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = BANNER;
        end
      end

      LEVELUP: begin
        if (level_q >= LAST_LEVEL) begin
          state_d = WIN;
        end else begin
          level_d = level_q + LEVEL_WIDTH'(1);
          state_d = BANNER;
        end
      end

      BANNER: begin
        if (tick_in) begin
          if (bannerCnt_q >= LAST_TICK) begin
            bannerCnt_d = '0;
            state_d     = PLAY;
          end else begin
            bannerCnt_d = bannerCnt_q + BANNER_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter controls and status flags are decoded from the state we are about
  // to enter, then registered, so they line up with state_out cycle for cycle.
  // The counter is only released from clear while actually playing.
  always_comb begin
    clear_d    = 1'b1;
    enable_d   = 1'b0;
    win_d      = (state_d == WIN);
    gameover_d = (state_d == GAMEOVER);

    case (state_d)
      PLAY: begin
        clear_d  = 1'b0;
        enable_d = 1'b1;
      end
      BANNER: begin
        enable_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and output registers. Reset lands everything in IDLE and drops any
  // count strobe that would otherwise have gone out on the next cycle.
  always_ff @(posedge SC_LEVELSEQUENCER_CLOCK_50) begin
    if (SC_LEVELSEQUENCER_RESET_InHigh) begin
      state_q     <= IDLE;
      level_q     <= '0;
      lives_q     <= 2'd0;
      bannerCnt_q <= '0;
      countN_q    <= 1'b1;
      clear_q     <= 1'b1;
      enable_q    <= 1'b0;
      win_q       <= 1'b0;
      gameover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      bannerCnt_q <= bannerCnt_d;
      countN_q    <= countN_d;
      clear_q     <= clear_d;
      enable_q    <= enable_d;
      win_q       <= win_d;
      gameover_q  <= gameover_d;
    end
  end

  assign cnt_count_n_out = countN_q;
  assign cnt_clear_out   = clear_q;
  assign cnt_enable_out  = enable_q;
  assign level_out       = level_q;
  assign lives_out       = lives_q;
  assign state_out       = state_q;
  assign win_out         = win_q;
  assign gameover_out    = gameover_q;

endmodule
